core_mem_responder: RTL and testbench
=====================================

# core_mem_responder

Memory-side responder for the Core data-memory port. It accepts one read or write request at a time on the enable_M/addr_M/wr_data_M lines, serves it from a local single-port array after a fixed latency, and returns read data with a one-cycle ready_M pulse. It replaces the behavioural memory model in Core-level benches and is the memory endpoint in the integrated GPU top.

## Interface
Parameters:
- DATA_W, 8: data width; matches the Core register width.
- ADDR_W, 8: address width; array depth is 2^ADDR_W words.
- LATENCY, 2: cycles from request acceptance to ready_M; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable_M  in  2  request code: 2'b00 none, 2'b01 read, 2'b10 write, 2'b11 illegal.
- addr_M  in  ADDR_W  word address.
- wr_data_M  in  DATA_W  write data.
- rd_data_M  out  DATA_W  read data; registered.
- ready_M  out  1  completion pulse, one cycle wide.
- err_M  out  1  sticky protocol-error flag; present only with CORE_MEM_CHECK_EN.

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: when enable_M != 0, latch op, addr and data; load cnt = LATENCY-1; go to BUSY, or go directly to RESP if LATENCY = 1.
- BUSY: decrement cnt each cycle; go to RESP when cnt = 1.
- On the edge entering RESP, the access executes:
  - Write: array[addr] <= data.
  - Read: rd_data_M <= array[addr].
  - Illegal (2'b11): executes as a read; no write occurs.
- RESP: ready_M = 1 for this one cycle; return to IDLE.
- In IDLE, any nonzero enable_M is a new request. The Core drops or changes enable_M in the cycle after ready_M.
- Inputs are ignored while in BUSY and RESP; the latched copies are used.
- rd_data_M holds its value until the next read or illegal response. Writes do not alter it.

## Timing
- Reset values:
  - state IDLE, cnt 0, ready_M 0, rd_data_M 0, err_M 0.
  - Array contents are not cleared.
- Request sampled in IDLE at edge t; ready_M is high during cycle t+LATENCY.
- Read data is valid in the same cycle as ready_M.
- Write data is visible to any request accepted at edge t+LATENCY+1 or later.
- Throughput: one access per LATENCY+1 cycles when requests are back-to-back.
- Reset during BUSY aborts the access: no write is committed and no ready_M is issued.
- Reset asserted in RESP drops ready_M on the next edge. The write has already committed.
- Address wrap-around does not occur; addr_M covers the full array exactly.

## Configuration
- CORE_MEM_CHECK_EN defined:
  - A protocol checker sets err_M (sticky until reset) on any of:
    - enable_M = 2'b11 sampled in IDLE;
    - enable_M, addr_M or wr_data_M changing while BUSY or RESP, unless enable_M goes to 0 in RESP.
  - Each violation also prints $display in simulation.
- CORE_MEM_CHECK_EN undefined:
  - err_M port and checker logic are absent.
  - Functional behaviour is otherwise identical.

## Structure
- Shared package/def file holds:
  - MEM_OP_NONE/RD/WR/ILL codes for enable_M;
  - FSM state encodings;
  - default DATA_W/ADDR_W, aligned with the Core REG/ADDR range macros.
- One sub-module, core_mem_array: single-port synchronous RAM (we, addr, wdata, rdata registered). The responder FSM drives it.
- The checker stays inline under the macro, not a separate module.

## Test plan
- Reset, then LATENCY=2; write 0x5A to addr 0x03 (enable_M=2'b10) -> ready_M high exactly 2 cycles after acceptance, for 1 cycle; rd_data_M stays 0.
- Read addr 0x03 immediately after that write -> ready_M 2 cycles later with rd_data_M = 0x5A.
- Back-to-back writes 0x11@0x00 then 0x22@0xFF, then reads of both -> 0x11 and 0x22 returned; one ready_M per request, spaced 3 cycles apart.
- Assert reset one cycle into BUSY of write 0x77@0x10; then read 0x10 -> old contents returned (not 0x77); no ready_M during reset.
- LATENCY=1: read request -> ready_M in the very next cycle.
- With CORE_MEM_CHECK_EN: enable_M=2'b11 -> served as a read, err_M=1 and held until reset. Change addr_M during BUSY -> err_M=1 and the original address is served.

Source files
------------

// File: rtl/core_mem_responder_pkg.sv
// rtl/core_mem_responder_pkg.sv - shared op codes, FSM states and default widths for core_mem_responder
// Default widths track the Core register/address range.
package core_mem_responder_pkg;

  localparam int CORE_DATA_W = 8;
  localparam int CORE_ADDR_W = 8;
  localparam int CNT_W       = 4;

  localparam logic [1:0] MEM_OP_NONE = 2'b00;
  localparam logic [1:0] MEM_OP_RD   = 2'b01;
  localparam logic [1:0] MEM_OP_WR   = 2'b10;
  localparam logic [1:0] MEM_OP_ILL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Illegal codes are served as reads, so only the write code stores.
  function automatic logic op_is_write(input logic [1:0] op);
    return op == MEM_OP_WR;
  endfunction

endpackage

// File: rtl/core_mem_array.sv
// rtl/core_mem_array.sv - single-port synchronous RAM with registered read data
// Read data only updates on a read access, so it holds across writes.
module core_mem_array
  import core_mem_responder_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int ADDR_W = CORE_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/core_mem_responder.sv
// rtl/core_mem_responder.sv - fixed-latency memory responder for the Core data port
// Optional protocol checker and err_M port under CORE_MEM_CHECK_EN.
module core_mem_responder
  import core_mem_responder_pkg::*;
#(
  parameter int DATA_W  = CORE_DATA_W,
  parameter int ADDR_W  = CORE_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        enable_M,
  input  logic [ADDR_W-1:0] addr_M,
  input  logic [DATA_W-1:0] wr_data_M,
  output logic [DATA_W-1:0] rd_data_M,
  output logic              ready_M
`ifdef CORE_MEM_CHECK_EN
  ,
  output logic              err_M
`endif
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  logic              w_accept;
  logic              w_from_idle;
  logic              w_enter_resp;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [1:0]        w_mem_op;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (enable_M != MEM_OP_NONE) begin
          w_next = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_M = (r_state == ST_RESP);
  end

  assign w_accept    = (r_state == ST_IDLE) && (enable_M != MEM_OP_NONE);
  assign w_from_idle = (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= LAT_M1;
    end else if (r_state == ST_BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op   <= enable_M;
      r_addr <= addr_M;
      r_data <= wr_data_M;
    end
  end

  // With LATENCY=1 the access fires on the accepting edge, before the latches hold the request.
  assign w_mem_op     = w_from_idle ? enable_M  : r_op;
  assign w_mem_addr   = w_from_idle ? addr_M    : r_addr;
  assign w_mem_wdata  = w_from_idle ? wr_data_M : r_data;
  assign w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);
  assign w_mem_en     = w_enter_resp && !reset;
  assign w_mem_we     = op_is_write(w_mem_op);

  core_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .o_rdata (rd_data_M)
  );

`ifdef CORE_MEM_CHECK_EN
  logic r_err;
  logic w_violation;

  // Dropping enable_M to none during RESP is the normal end of a request.
  always_comb begin
    w_violation = 1'b0;
    if (w_accept && (enable_M == MEM_OP_ILL)) begin
      w_violation = 1'b1;
    end else if ((r_state == ST_BUSY) ||
                 ((r_state == ST_RESP) && (enable_M != MEM_OP_NONE))) begin
      w_violation = (enable_M != r_op) || (addr_M != r_addr) || (wr_data_M != r_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_violation) begin
      r_err <= 1'b1;
    end
  end

  assign err_M = r_err;
`endif

endmodule

// File: tb/tb_core_mem_responder.sv
// tb/tb_core_mem_responder.sv - randomized self-checking bench for core_mem_responder (LATENCY 2 and 1)
module tb_core_mem_responder;
  import core_mem_responder_pkg::*;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] en_m   [2];
  logic [7:0] addr_m [2];
  logic [7:0] wd_m   [2];
  logic [7:0] rd_m   [2];
  logic       rdy_m  [2];
`ifdef CORE_MEM_CHECK_EN
  logic       err_m  [2];
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  core_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(LAT0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .enable_M  (en_m[0]),
    .addr_M    (addr_m[0]),
    .wr_data_M (wd_m[0]),
    .rd_data_M (rd_m[0]),
    .ready_M   (rdy_m[0])
`ifdef CORE_MEM_CHECK_EN
    ,
    .err_M     (err_m[0])
`endif
  );

  core_mem_responder #(.DATA_W(8), .ADDR_W(8), .LATENCY(LAT1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .enable_M  (en_m[1]),
    .addr_M    (addr_m[1]),
    .wr_data_M (wd_m[1]),
    .rd_data_M (rd_m[1]),
    .ready_M   (rdy_m[1])
`ifdef CORE_MEM_CHECK_EN
    ,
    .err_M     (err_m[1])
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: per-instance word store, written flags and the last returned read value.
  logic [7:0] mdl   [2][256];
  bit         known [2][256];
  logic [7:0] exp_rd[2];
  int         lat_of[2];
  int         last_rdy[2];

  task automatic run_req(input int d, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] dat, input bit chk_gap);
    @(negedge clk);
    check_val("ready_low_idle", rdy_m[d], 0);
    en_m[d] = op; addr_m[d] = a; wd_m[d] = dat;
    @(posedge clk);
    for (int k = 0; k < lat_of[d]; k++) begin
      @(negedge clk);
      if (k < lat_of[d] - 1) check_val("ready_early", rdy_m[d], 0);
    end
    check_val("ready_pulse", rdy_m[d], 1);
    if (op == MEM_OP_WR) begin
      mdl[d][a] = dat;
      known[d][a] = 1'b1;
    end else if (known[d][a]) begin
      exp_rd[d] = mdl[d][a];
    end
    check_val("rd_data", rd_m[d], exp_rd[d]);
    if (chk_gap) check_val("ready_gap", cyc - last_rdy[d], lat_of[d] + 1);
    last_rdy[d] = cyc;
    en_m[d] = MEM_OP_NONE;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    en_m[0] = MEM_OP_NONE; en_m[1] = MEM_OP_NONE;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  logic [1:0] r_op;
  logic [7:0] r_a;

  initial begin
    lat_of[0] = LAT0; lat_of[1] = LAT1;
    last_rdy[0] = 0; last_rdy[1] = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 256; i++) begin
        known[d][i] = 1'b0;
        mdl[d][i] = '0;
      end
      en_m[d] = MEM_OP_NONE; addr_m[d] = '0; wd_m[d] = '0;
    end

    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_ready0", rdy_m[0], 0);
    check_val("reset_rd0", rd_m[0], 0);
    check_val("reset_ready1", rdy_m[1], 0);
    check_val("reset_rd1", rd_m[1], 0);
`ifdef CORE_MEM_CHECK_EN
    check_val("reset_err0", err_m[0], 0);
`endif
    reset = 1'b0;

    run_req(0, MEM_OP_WR, 8'h03, 8'h5A, 1'b0);
    run_req(0, MEM_OP_RD, 8'h03, 8'h00, 1'b1);
    run_req(0, MEM_OP_WR, 8'h00, 8'h11, 1'b1);
    run_req(0, MEM_OP_WR, 8'hFF, 8'h22, 1'b1);
    run_req(0, MEM_OP_RD, 8'h00, 8'h00, 1'b1);
    run_req(0, MEM_OP_RD, 8'hFF, 8'h00, 1'b1);

    run_req(0, MEM_OP_WR, 8'h10, 8'h33, 1'b0);
    @(negedge clk);
    en_m[0] = MEM_OP_WR; addr_m[0] = 8'h10; wd_m[0] = 8'h77;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    en_m[0] = MEM_OP_NONE;
    @(posedge clk);
    @(negedge clk);
    check_val("ready_in_reset", rdy_m[0], 0);
    check_val("rd_after_reset", rd_m[0], 0);
    reset = 1'b0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    run_req(0, MEM_OP_RD, 8'h10, 8'h00, 1'b0);

    run_req(1, MEM_OP_WR, 8'h20, 8'hA5, 1'b0);
    run_req(1, MEM_OP_RD, 8'h20, 8'h00, 1'b1);
    run_req(1, MEM_OP_ILL, 8'h20, 8'h3C, 1'b1);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 40; i++) begin
        r_op = 2'($urandom_range(0, 3));
        if (r_op == MEM_OP_NONE) r_op = MEM_OP_WR;
        r_a = 8'($urandom_range(0, 15)) | (($urandom_range(0, 1) == 1) ? 8'hF0 : 8'h00);
        if (r_op != MEM_OP_WR && !known[d][r_a]) r_op = MEM_OP_WR;
        run_req(d, r_op, r_a, 8'($urandom_range(0, 255)), i > 0);
      end
    end

`ifdef CORE_MEM_CHECK_EN
    pulse_reset();
    check_val("err_cleared", err_m[0], 0);
    run_req(0, MEM_OP_ILL, 8'h03, 8'h00, 1'b0);
    check_val("err_illegal", err_m[0], 1);
    repeat (3) @(negedge clk);
    check_val("err_sticky", err_m[0], 1);
    pulse_reset();
    check_val("err_reset", err_m[0], 0);
    en_m[0] = MEM_OP_RD; addr_m[0] = 8'h03; wd_m[0] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    addr_m[0] = 8'h00;
    @(negedge clk);
    check_val("addr_chg_ready", rdy_m[0], 1);
    exp_rd[0] = mdl[0][8'h03];
    check_val("addr_chg_rd", rd_m[0], exp_rd[0]);
    en_m[0] = MEM_OP_NONE;
    @(negedge clk);
    check_val("err_addr_chg", err_m[0], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
